power_seq: RTL

//  Sequential integer exponentiation unit for the calculator datapath; computes

---
 rtl/power_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/power_seq.sv
// -----------------------------------------------------------------------------
// power_seq
//
// Sequential unsigned integer exponentiation: result = base ** exponent,
// reduced modulo 2**RES_W. The exponent is consumed LSB first by
// square-and-multiply. One exponent bit is processed per clock.
//
// A request is accepted only in IDLE. The unit then spends
// max(1, bit-length(exponent)) cycles in CALC. It then spends one cycle in
// DONE, where done pulses and result/overflow are already valid.
// result/overflow hold their values until the next DONE or until reset.
// overflow reports that the true (unreduced) power is >= 2**RES_W.
//
// Ports
//   clk       in   1        clock; all state changes on the rising edge
//   rst       in   1        synchronous reset, active-high, highest priority
//   start     in   1        operation request, honoured only in IDLE
//   base      in   BASE_W   base operand, captured with an accepted start
//   exponent  in   EXP_W    exponent operand, captured with an accepted start
//   busy      out  1        high while in CALC
//   done      out  1        one-cycle pulse; result/overflow valid
//   result    out  RES_W    base**exponent mod 2**RES_W
//   overflow  out  1        true power did not fit in RES_W bits
// -----------------------------------------------------------------------------
module power_seq #(
    parameter int BASE_W = 4,
    parameter int EXP_W  = 4,
    parameter int RES_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BASE_W-1:0] base,
    input  logic [EXP_W-1:0]  exponent,
    output logic              busy,
    output logic              done,
    output logic [RES_W-1:0]  result,
    output logic              overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int PROD_W = 2 * RES_W;

    state_t             state_q,    state_d;
    logic [RES_W-1:0]   acc_q,      acc_d;       // running product
    logic [RES_W-1:0]   sq_q,       sq_d;        // base**(2**k), truncated
    logic [EXP_W-1:0]   e_q,        e_d;         // unconsumed exponent bits
    logic               sq_big_q,   sq_big_d;    // true sq no longer fits
    logic               ovf_q,      ovf_d;       // true acc no longer fits
    logic [RES_W-1:0]   result_q,   result_d;
    logic               overflow_q, overflow_d;

    // Full-width products. The upper halves are the overflow indicators.
    // The lower halves are the exact modular values.
    logic [PROD_W-1:0]  prod_acc;
    logic [PROD_W-1:0]  prod_sq;
    logic               prod_acc_big;
    logic               prod_sq_big;
    logic [EXP_W-1:0]   e_shift;

    assign prod_acc     = PROD_W'(acc_q) * PROD_W'(sq_q);
    assign prod_sq      = PROD_W'(sq_q)  * PROD_W'(sq_q);
    assign prod_acc_big = |prod_acc[PROD_W-1:RES_W];
    assign prod_sq_big  = |prod_sq[PROD_W-1:RES_W];
    assign e_shift      = e_q >> 1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            sq_q       <= '0;
            e_q        <= '0;
            sq_big_q   <= 1'b0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            sq_q       <= sq_d;
            e_q        <= e_d;
            sq_big_q   <= sq_big_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sq_d       = sq_q;
        e_d        = e_q;
        sq_big_d   = sq_big_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        overflow_d = overflow_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d    = RES_W'(1);
                    sq_d     = RES_W'(base);
                    e_d      = exponent;
                    sq_big_d = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = ST_CALC;
                end
            end

            ST_CALC: begin
                // A big square only matters when it is multiplied into acc.
                // A square formed after the last set bit is discarded and
                // never raises overflow.
                if (e_q[0]) begin
                    acc_d = prod_acc[RES_W-1:0];
                    ovf_d = ovf_q | sq_big_q | prod_acc_big;
                end
                sq_d     = prod_sq[RES_W-1:0];
                sq_big_d = sq_big_q | prod_sq_big;
                e_d      = e_shift;

                // An exponent of zero still costs one CALC cycle.
                if (e_shift == '0) begin
                    state_d    = ST_DONE;
                    // Register the outputs on entry to DONE so they are
                    // valid in the same cycle as the done pulse.
                    result_d   = acc_d;
                    overflow_d = ovf_d;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_q == ST_CALC);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule
